dmem: RTL and testbench

Byte-addressable data memory for the single-cycle RV32I core, sitting on the MEM path between the ALU address output and the register-file write-back mux. It performs RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) selected by a funct3-style mode code. Reads are combinational; writes commit on the rising clock edge. Reset clears the entire array.

---
 rtl/rv32i_pkg.sv | 28 ++
 rtl/dmem_load_ext.sv | 31 +++
 rtl/dmem.sv | 76 +++++++
 tb/tb_dmem.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32I data-memory path: load/store mode codes
// (funct3 encoding) and a helper that maps a store mode onto the byte lanes
// it writes.
// ---------------------------------------------------------------------------
package rv32i_pkg;

    localparam logic [2:0] MODE_B  = 3'b000;  // signed byte
    localparam logic [2:0] MODE_H  = 3'b001;  // signed half
    localparam logic [2:0] MODE_W  = 3'b010;  // word
    localparam logic [2:0] MODE_BU = 3'b100;  // unsigned byte
    localparam logic [2:0] MODE_HU = 3'b101;  // unsigned half

    // Byte lanes (relative to the access address) touched by a store.
    // The signed/unsigned variants store identically. Illegal codes touch nothing.
    function automatic logic [3:0] store_lanes(input logic [2:0] mode);
        logic [3:0] lanes;
        case (mode)
            MODE_B, MODE_BU: lanes = 4'b0001;
            MODE_H, MODE_HU: lanes = 4'b0011;
            MODE_W:          lanes = 4'b1111;
            default:         lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// ---------------------------------------------------------------------------
// dmem_load_ext
// Combinational load extender. Takes the four bytes at a, a+1, a+2, a+3
// (already assembled little-endian) and produces the load result for the
// requested mode.
//   i_raw  [31:0]  assembled bytes, byte at a in [7:0]
//   i_mode [2:0]   RV32I funct3 load mode
//   o_rd   [31:0]  sign/zero-extended load data; 0 for illegal modes
// ---------------------------------------------------------------------------
module dmem_load_ext
    import rv32i_pkg::*;
(
    input  logic [31:0] i_raw,
    input  logic [2:0]  i_mode,
    output logic [31:0] o_rd
);

    always_comb begin
        // NOTE: default first so every path assigns o_rd and no latch is inferred.
        o_rd = '0;
        case (i_mode)
            MODE_B:  o_rd = {{24{i_raw[7]}}, i_raw[7:0]};
            MODE_BU: o_rd = {24'h0, i_raw[7:0]};
            MODE_H:  o_rd = {{16{i_raw[15]}}, i_raw[15:0]};
            MODE_HU: o_rd = {16'h0, i_raw[15:0]};
            MODE_W:  o_rd = i_raw;
            default: o_rd = '0;
        endcase
    end

endmodule

// File: rtl/dmem.sv
// ---------------------------------------------------------------------------
// dmem
// Byte-addressable little-endian data memory for the single-cycle RV32I
// core. Loads are combinational, stores commit on the rising clock edge.
// Every access is split into four byte lanes, each with its own address,
// so misaligned accesses and wrap-around at the top of the array need no
// special casing.
//   clk         system clock, stores on rising edge
//   reset       asynchronous active-low; clears the whole array, blocks stores
//   a    [31:0] byte address, only [ADDR_WIDTH-1:0] used (upper bits alias)
//   wd   [31:0] store data (low byte / low half / full word per mode)
//   we          store enable
//   mode [2:0]  RV32I funct3 access size/sign
//   rd   [31:0] load data, combinational
// ---------------------------------------------------------------------------
module dmem
    import rv32i_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic        we,
    input  logic [2:0]  mode,
    output logic [31:0] rd
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [7:0]            r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_lane_addr [4];
    logic [3:0]            w_lanes;
    logic [31:0]           w_raw;

    // Upper address bits are deliberately ignored (aliasing).
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^a[31:ADDR_WIDTH];

    // Lane k addresses byte a+k; the narrow adder wraps modulo DEPTH.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_lane_addr[k] = a[ADDR_WIDTH-1:0] + ADDR_WIDTH'(k);
        end
    end

    assign w_lanes = store_lanes(mode);

    // NOTE: the array is cleared by reset because the core relies on memory
    // reading 0 after reset; this costs a reset net on every byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_lanes[k]) begin
                    r_mem[w_lane_addr[k]] <= wd[8*k +: 8];
                end
            end
        end
    end

    // Little-endian assembly: byte at a lands in bits [7:0].
    assign w_raw = {r_mem[w_lane_addr[3]], r_mem[w_lane_addr[2]],
                    r_mem[w_lane_addr[1]], r_mem[w_lane_addr[0]]};

    dmem_load_ext u_load_ext (
        .i_raw  (w_raw),
        .i_mode (mode),
        .o_rd   (rd)
    );

endmodule

// File: tb/tb_dmem.sv
// ---------------------------------------------------------------------------
// tb_dmem
// Self-checking bench for dmem: directed stores followed by tables of
// {address, mode, expected load} vectors, plus hand-written sequences for
// write timing and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_dmem;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic [2:0]  mode;
    logic [31:0] rd;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          phase;
        string       name;
        logic [31:0] a;
        logic [2:0]  mode;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    dmem #(.ADDR_WIDTH(10)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .wd    (wd),
        .we    (we),
        .mode  (mode),
        .rd    (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Store one access: inputs set after a falling edge, commit on the next rising edge.
    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] m);
        @(negedge clk);
        a    = addr;
        wd   = data;
        mode = m;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we   = 1'b0;
    endtask

    task automatic run_phase(input int p);
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].phase == p) begin
                a    = vecs[i].a;
                mode = vecs[i].mode;
                #1;
                check(vecs[i].name, rd, vecs[i].exp);
            end
        end
    endtask

    initial begin
        // phase 1: word 0xF00AA00F at 4
        vecs[0]  = '{1, "w_rt_word",   32'h4,    3'b010, 32'hF00AA00F};
        vecs[1]  = '{1, "w_rt_lb4",    32'h4,    3'b000, 32'h0000000F};
        vecs[2]  = '{1, "w_rt_lb5",    32'h5,    3'b000, 32'hFFFFFFA0};
        vecs[3]  = '{1, "w_rt_lbu5",   32'h5,    3'b100, 32'h000000A0};
        // phase 2: misaligned half 0xFFFF at 5
        vecs[4]  = '{2, "mis_word",    32'h4,    3'b010, 32'hF0FFFF0F};
        vecs[5]  = '{2, "mis_lhu5",    32'h5,    3'b101, 32'h0000FFFF};
        // phase 3: bytes 0xAA@10, 0xBB@11
        vecs[6]  = '{3, "byte_lh10",   32'hA,    3'b001, 32'hFFFFBBAA};
        vecs[7]  = '{3, "byte_lhu10",  32'hA,    3'b101, 32'h0000BBAA};
        // phase 4: illegal-mode store at 12 wrote nothing, illegal loads read 0
        vecs[8]  = '{4, "ill_word12",  32'hC,    3'b010, 32'h00000000};
        vecs[9]  = '{4, "ill_rd011",   32'hC,    3'b011, 32'h00000000};
        vecs[10] = '{4, "ill_rd110",   32'h4,    3'b110, 32'h00000000};
        vecs[11] = '{4, "ill_rd111",   32'h4,    3'b111, 32'h00000000};
        vecs[12] = '{4, "ill_rd011_4", 32'h4,    3'b011, 32'h00000000};
        // phase 5: word 0x11223344 at 0x3FF wraps to bytes 0..2
        vecs[13] = '{5, "wrap_word",   32'h3FF,  3'b010, 32'h11223344};
        vecs[14] = '{5, "wrap_b3ff",   32'h3FF,  3'b100, 32'h00000044};
        vecs[15] = '{5, "wrap_b0",     32'h0,    3'b100, 32'h00000033};
        vecs[16] = '{5, "wrap_b1",     32'h1,    3'b100, 32'h00000022};
        vecs[17] = '{5, "wrap_b2",     32'h2,    3'b100, 32'h00000011};
        vecs[18] = '{5, "wrap_lb0",    32'h0,    3'b000, 32'h00000033};
        vecs[19] = '{5, "wrap_lhu0",   32'h0,    3'b101, 32'h00002233};
        vecs[20] = '{5, "alias_word",  32'h1404, 3'b010, 32'hF0FFFF0F};
        vecs[21] = '{5, "alias_hi",    32'hFFFFFC04, 3'b010, 32'hF0FFFF0F};

        a     = '0;
        wd    = '0;
        we    = 1'b0;
        mode  = 3'b010;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #10;
        a = 32'h4;
        #1;
        check("reset_rd", rd, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_reset_rd", rd, 32'h0);

        store(32'h4, 32'hF00AA00F, 3'b010);
        run_phase(1);

        store(32'h5, 32'hFFFFFFFF, 3'b001);
        run_phase(2);

        store(32'hA, 32'h000000AA, 3'b000);
        store(32'hB, 32'h000000BB, 3'b000);
        run_phase(3);

        store(32'hC, 32'h12345678, 3'b011);
        run_phase(4);

        store(32'h3FF, 32'h11223344, 3'b010);
        run_phase(5);

        // No bypass: rd shows old contents until the rising edge commits wd.
        @(negedge clk);
        a    = 32'h14;
        wd   = 32'hDEADBEEF;
        mode = 3'b010;
        we   = 1'b1;
        #1;
        check("no_bypass", rd, 32'h00000000);
        @(posedge clk);
        #1;
        we = 1'b0;
        check("commit_word", rd, 32'hDEADBEEF);
        mode = 3'b001;
        #1;
        check("commit_lh", rd, 32'hFFFFBEEF);

        // Asynchronous reset mid-cycle, no clock edge involved.
        @(negedge clk);
        a    = 32'h4;
        mode = 3'b010;
        #2;
        reset = 1'b0;
        #1;
        check("async_rd4", rd, 32'h0);
        a = 32'h3FF;
        #1;
        check("async_rd3ff", rd, 32'h0);

        // Store attempted while reset is held low is discarded.
        @(negedge clk);
        a    = 32'h8;
        wd   = 32'hCAFEBABE;
        mode = 3'b010;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_drop_8", rd, 32'h0);
        a = 32'h4;
        #1;
        check("rst_clr_4", rd, 32'h0);
        a = 32'h14;
        #1;
        check("rst_clr_14", rd, 32'h0);

        // Memory is writable again after release.
        store(32'h8, 32'h0000807F, 3'b001);
        mode = 3'b000;
        #1;
        check("after_rst_lb8", rd, 32'h0000007F);
        a = 32'h9;
        #1;
        check("after_rst_lb9", rd, 32'hFFFFFF80);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
